// File: rtl/rr_pop_arbiter.sv
// ---------------------------------------------------------------------------
// rr_pop_arbiter
//
// Upstream stage of the 4-lane routing arbiter. Picks one of four
// first-word-fall-through input FIFOs using a round-robin policy with a
// bounded burst per lane. It pops at most one word per cycle and forwards
// that word, registered, to the intermediate FIFO. A pop happens only when
// the intermediate FIFO is not almost full, so a popped word can always be
// pushed.
//
// Parameters
//   DATA_WIDTH  word width; the top two bits carry the destination lane and
//               pass through unchanged
//   BURST       maximum consecutive pops granted to one lane (1..15)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   fifo_empty   per-lane empty flags of the input FIFOs
//   fifo_data    FWFT head words, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   almost_full  intermediate FIFO back-pressure; 1 blocks popping
//   pop          combinational one-hot (or zero) pop strobe
//   push         registered write strobe to the intermediate FIFO
//   data_out     registered word that accompanies push
//   grant_id     registered lane index of the word on data_out
// ---------------------------------------------------------------------------
module rr_pop_arbiter #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned BURST      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                fifo_empty,
    input  logic [4*DATA_WIDTH-1:0]   fifo_data,
    input  logic                      almost_full,
    output logic [3:0]                pop,
    output logic                      push,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [1:0]                grant_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [3:0] BURST_C = 4'(BURST);

    state_e                state_q, state_d;
    logic [1:0]            cur_q, cur_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  push_q, push_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            gid_q, gid_d;

    logic                  permit;
    logic [1:0]            search_start;
    logic                  found;
    logic [1:0]            winner;
    logic                  sel_valid;
    logic [1:0]            sel_lane;
    logic [DATA_WIDTH-1:0] lane_word [4];

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            lane_word[i] = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Popping is allowed only out of reset and without back-pressure.
    assign permit = reset & ~almost_full;

    // In IDLE the search starts at ptr. During a handover it starts at cur+1,
    // which naturally leaves the current lane as the last candidate.
    always_comb begin
        logic [1:0] lane;
        lane         = '0;
        found        = 1'b0;
        search_start = (state_q == IDLE) ? ptr_q : cur_q + 2'd1;
        winner       = search_start;
        for (int unsigned i = 0; i < 4; i++) begin
            lane = search_start + 2'(i);
            if (!found && !fifo_empty[lane]) begin
                found  = 1'b1;
                winner = lane;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sel_valid = 1'b0;
        sel_lane  = cur_q;

        if (permit) begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        sel_valid = 1'b1;
                        sel_lane  = winner;
                        cur_d     = winner;
                        cnt_d     = 4'd1;
                        ptr_d     = winner + 2'd1;
                        state_d   = GRANT;
                    end
                end
                GRANT: begin
                    if (!fifo_empty[cur_q] && (cnt_q < BURST_C)) begin
                        sel_valid = 1'b1;
                        sel_lane  = cur_q;
                        cnt_d     = cnt_q + 4'd1;
                    end else if (found) begin
                        // Handover happens in the same cycle, so the next
                        // lane is popped with no bubble.
                        sel_valid = 1'b1;
                        sel_lane  = winner;
                        cur_d     = winner;
                        cnt_d     = 4'd1;
                        ptr_d     = winner + 2'd1;
                    end else begin
                        state_d = IDLE;
                        ptr_d   = cur_q + 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pop = sel_valid ? (4'b0001 << sel_lane) : 4'b0000;

    always_comb begin
        push_d = sel_valid;
        data_d = data_q;
        gid_d  = gid_q;
        if (sel_valid) begin
            data_d = lane_word[sel_lane];
            gid_d  = sel_lane;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            push_q  <= 1'b0;
            data_q  <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            push_q  <= push_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
        end
    end

    assign push     = push_q;
    assign data_out = data_q;
    assign grant_id = gid_q;

endmodule
